// File: rtl/output_packer_if.sv
// Pixel stream and RIFFA TX channel bundle for output_packer.
// master = upstream interpolator + host, slave = the packer.
interface output_packer_if;
    logic [31:0] pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        chnl_tx;
    logic        chnl_tx_ack;
    logic        chnl_tx_last;
    logic [31:0] chnl_tx_len;
    logic [30:0] chnl_tx_off;
    logic [63:0] chnl_tx_data;
    logic        chnl_tx_data_valid;
    logic        chnl_tx_data_ren;

    modport master (
        output pixel_in, pixel_valid, chnl_tx_ack, chnl_tx_data_ren,
        input  pixel_ready, chnl_tx, chnl_tx_last, chnl_tx_len, chnl_tx_off,
               chnl_tx_data, chnl_tx_data_valid
    );

    modport slave (
        input  pixel_in, pixel_valid, chnl_tx_ack, chnl_tx_data_ren,
        output pixel_ready, chnl_tx, chnl_tx_last, chnl_tx_len, chnl_tx_off,
               chnl_tx_data, chnl_tx_data_valid
    );
endinterface

// File: rtl/output_packer.sv
// Saturates interpolated pixels to 8 bits, packs eight per 64-bit word and
// returns one frame per start over a RIFFA TX channel through a FWFT word FIFO.
module output_packer #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [31:0]    out_rows,
    input  logic [31:0]    out_cols,
    output logic           done,
    output logic           overflow,
    output_packer_if.slave bus
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   total_q, total_d;
    logic [31:0]   words_q, words_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   accepted_q, accepted_d;
    logic [31:0]   sent_q, sent_d;
    logic [2:0]    lane_q, lane_d;
    logic [63:0]   word_q, word_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic          start_ok;
    logic [31:0]   start_total;
    logic [31:0]   start_words;
    logic          ready_c;
    logic          data_valid_c;
    logic          accept;
    logic          pop;
    logic          push;
    logic [7:0]    sat;
    logic [63:0]   push_word;

    assign start_ok     = start && (state_q == ST_IDLE);
    assign start_total  = out_rows * out_cols;
    assign start_words  = 32'((33'(start_total) + 33'd7) >> 3);
    assign ready_c      = ((state_q == ST_REQ) || (state_q == ST_SEND)) && !full_q
                          && (accepted_q < total_q);
    assign data_valid_c = (state_q == ST_SEND) && !empty_q;
    assign accept       = bus.pixel_valid && ready_c;
    assign pop          = data_valid_c && bus.chnl_tx_data_ren;

    // Signed clamp to [0,255]
    always_comb begin
        sat = bus.pixel_in[7:0];
        if (bus.pixel_in[31]) begin
            sat = 8'd0;
        end else if (|bus.pixel_in[30:8]) begin
            sat = 8'hFF;
        end
    end

    // Frame sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (start_total != 32'd0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (bus.chnl_tx_ack) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pop && ((sent_q + 32'd1) == words_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Packing, counters and FIFO bookkeeping
    always_comb begin
        total_d    = total_q;
        words_d    = words_q;
        len_d      = len_q;
        accepted_d = accepted_q;
        sent_d     = sent_q;
        lane_d     = lane_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_word  = word_q | (64'(sat) << {lane_q, 3'b000});

        if (start_ok) begin
            total_d    = start_total;
            words_d    = start_words;
            len_d      = 32'(start_words << 1);
            accepted_d = 32'd0;
            sent_d     = 32'd0;
            lane_d     = 3'd0;
            word_d     = 64'd0;
            overflow_d = 1'b0;
        end

        if (accept) begin
            accepted_d = accepted_q + 32'd1;
            push       = (lane_q == 3'd7) || ((accepted_q + 32'd1) == total_q);
            if (push) begin
                word_d = 64'd0;
                lane_d = 3'd0;
            end else begin
                word_d = push_word;
                lane_d = lane_q + 3'd1;
            end
        end

        // Dropped pixel is a sticky error; it wins over the clear on start
        if (bus.pixel_valid && !ready_c) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            sent_d = sent_q + 32'd1;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == CW'(0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total_q    <= 32'd0;
            words_q    <= 32'd0;
            len_q      <= 32'd0;
            accepted_q <= 32'd0;
            sent_q     <= 32'd0;
            lane_q     <= 3'd0;
            word_q     <= 64'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            total_q    <= total_d;
            words_q    <= words_d;
            len_q      <= len_d;
            accepted_q <= accepted_d;
            sent_q     <= sent_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Word storage needs no reset: pointers and count define validity
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.pixel_ready        = ready_c;
    assign bus.chnl_tx            = (state_q == ST_REQ) || (state_q == ST_SEND);
    assign bus.chnl_tx_last       = 1'b1;
    assign bus.chnl_tx_len        = len_q;
    assign bus.chnl_tx_off        = 31'd0;
    assign bus.chnl_tx_data_valid = data_valid_c;
    assign bus.chnl_tx_data       = data_valid_c ? mem_q[rd_ptr_q] : 64'd0;
    assign done                   = (state_q == ST_DONE);
    assign overflow               = overflow_q;

endmodule
